// File: rtl/dr_pkg.sv
// Shared types and constants for the DR buffer read path.
//   rd_state_t : read scheduler FSM state
//   rd_tag_t   : per-issue tag carried through the RAM latency delay line
package dr_pkg;

  localparam int unsigned DR_NUM_BANKS  = 4;
  localparam int unsigned DR_RE_PER_PRB = 12;
  localparam int unsigned DR_BANK_W     = 2;
  localparam int unsigned DR_OCC_W      = 3;
  localparam int unsigned DR_PRB_W      = 9;

  typedef enum logic [0:0] {
    RS_IDLE = 1'b0,
    RS_READ = 1'b1
  } rd_state_t;

  // One-hot bank enable plus "last word of block" marker for one read issue.
  typedef struct packed {
    logic [DR_NUM_BANKS-1:0] ren;
    logic                    last;
  } rd_tag_t;

endpackage

// File: rtl/dr_buffer_rd_sched_if.sv
// Bus between the DR read scheduler and its environment.
//   i_wr_wlast  writer completed one block (pulse)
//   i_rready    downstream accepts a read this cycle
//   o_rd_*      bank read enable / address / bank index
//   o_dout_*    output mux select and valid, aligned to RAM latency
//   o_tx_*      RE/PRB framing of the output stream
//   o_occupancy/o_full/o_overflow  ring fill status
// master: environment side, slave: scheduler side.
interface dr_buffer_rd_sched_if #(
  parameter int unsigned RADDR_WIDTH = 11
) ();

  logic                   i_wr_wlast;
  logic                   i_rready;
  logic [3:0]             o_rd_ren;
  logic [RADDR_WIDTH-1:0] o_rd_addr;
  logic [1:0]             o_rd_bank;
  logic [3:0]             o_dout_sel;
  logic                   o_dout_vld;
  logic                   o_tx_sop;
  logic                   o_tx_eop;
  logic [8:0]             o_prb_idx;
  logic [2:0]             o_occupancy;
  logic                   o_full;
  logic                   o_overflow;

  modport master (
    output i_wr_wlast, i_rready,
    input  o_rd_ren, o_rd_addr, o_rd_bank, o_dout_sel, o_dout_vld,
           o_tx_sop, o_tx_eop, o_prb_idx, o_occupancy, o_full, o_overflow
  );

  modport slave (
    input  i_wr_wlast, i_rready,
    output o_rd_ren, o_rd_addr, o_rd_bank, o_dout_sel, o_dout_vld,
           o_tx_sop, o_tx_eop, o_prb_idx, o_occupancy, o_full, o_overflow
  );

endinterface

// File: rtl/dr_prb_framer.sv
// RE/PRB framing of the output word stream.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_vld          : a word leaves the RAM pipeline next cycle
//   i_blk_last     : that word is the last of its block
//   o_sop/o_eop    : registered start (RE0 of PRB0) / end (last RE) flags
//   o_prb_idx      : registered PRB index of the current output word
// Inputs are one stage ahead of the output valid so all outputs are registered.
module dr_prb_framer
  import dr_pkg::*;
#(
  parameter int unsigned RE_PER_PRB = DR_RE_PER_PRB,
  parameter int unsigned NUM_PRB    = 132,
  parameter int unsigned PRB_W      = DR_PRB_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic             i_blk_last,
  output logic             o_sop,
  output logic             o_eop,
  output logic [PRB_W-1:0] o_prb_idx
);

  localparam int unsigned RE_W = (RE_PER_PRB > 1) ? $clog2(RE_PER_PRB) : 1;

  logic [RE_W-1:0]  re_q, re_d;
  logic [PRB_W-1:0] prb_q, prb_d;
  logic [PRB_W-1:0] idx_q, idx_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             at_eop_c;

  // Counters describe the next word; they advance only on valid words.
  always_comb begin
    re_d     = re_q;
    prb_d    = prb_q;
    idx_d    = idx_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    at_eop_c = (re_q == RE_W'(RE_PER_PRB - 1));
    if (i_vld) begin
      sop_d = (re_q == '0) && (prb_q == '0);
      eop_d = at_eop_c;
      idx_d = prb_q;
      if (i_blk_last) begin
        re_d  = '0;
        prb_d = '0;
      end else if (at_eop_c) begin
        re_d  = '0;
        prb_d = (prb_q == PRB_W'(NUM_PRB - 1)) ? '0 : prb_q + PRB_W'(1);
      end else begin
        re_d = re_q + RE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      re_q  <= '0;
      prb_q <= '0;
      idx_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else begin
      re_q  <= re_d;
      prb_q <= prb_d;
      idx_q <= idx_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
    end
  end

  assign o_sop     = sop_q;
  assign o_eop     = eop_q;
  assign o_prb_idx = idx_q;

endmodule

// File: rtl/dr_buffer_rd_sched.sv
// Read scheduler for the 4-block DR ring buffer.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : wlast/rready in; bank enables, address, delayed select/valid,
//                    PRB framing and occupancy/full/overflow out (all registered)
// Owns read sequencing: counts full blocks, walks each block address by address
// while downstream is ready, and delays enables to the RAM latency.
module dr_buffer_rd_sched
  import dr_pkg::*;
#(
  parameter int unsigned RADDR_WIDTH  = 11,
  parameter int unsigned BLK_DEPTH    = 1584,
  parameter int unsigned NUM_BLOCKS   = 4,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned RE_PER_PRB   = DR_RE_PER_PRB,
  parameter int unsigned NUM_PRB      = 132
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  dr_buffer_rd_sched_if.slave  bus
);

  localparam logic [RADDR_WIDTH-1:0] LAST_ADDR = RADDR_WIDTH'(BLK_DEPTH - 1);
  localparam logic [DR_OCC_W-1:0]    OCC_MAX   = DR_OCC_W'(NUM_BLOCKS);

  rd_state_t                state_q, state_d;
  logic [RADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DR_BANK_W-1:0]     bank_q, bank_d;
  logic [DR_OCC_W-1:0]      occ_q, occ_d;
  logic                     full_q, full_d;
  logic                     ovf_q, ovf_d;
  logic [DR_NUM_BANKS-1:0]  ren_q, ren_d;
  logic [RADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DR_BANK_W-1:0]     rbank_q, rbank_d;
  logic                     last_q, last_d;
  logic                     vld_q;
  logic                     issue_c;
  logic                     retire_c;
  rd_tag_t                  pipe_q [READ_LATENCY];

  // Next-state: read issue, block retire, occupancy and FSM transitions.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bank_d   = bank_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    ren_d    = '0;
    addr_d   = addr_q;
    rbank_d  = rbank_q;
    last_d   = 1'b0;
    issue_c  = 1'b0;
    retire_c = 1'b0;

    case (state_q)
      RS_IDLE: issue_c = (occ_q != '0) && bus.i_rready;
      RS_READ: issue_c = bus.i_rready;
      default: state_d = RS_IDLE;
    endcase

    if (issue_c) begin
      ren_d   = DR_NUM_BANKS'(1) << bank_q;
      addr_d  = ptr_q;
      rbank_d = bank_q;
      if (ptr_q == LAST_ADDR) begin
        retire_c = 1'b1;
        last_d   = 1'b1;
        ptr_d    = '0;
        bank_d   = bank_q + DR_BANK_W'(1);
      end else begin
        ptr_d = ptr_q + RADDR_WIDTH'(1);
      end
    end

    // Simultaneous wlast and retire cancel; a wlast with no room is lost and flagged.
    if (bus.i_wr_wlast && !retire_c) begin
      if (occ_q == OCC_MAX) ovf_d = 1'b1;
      else                  occ_d = occ_q + DR_OCC_W'(1);
    end else if (!bus.i_wr_wlast && retire_c) begin
      occ_d = occ_q - DR_OCC_W'(1);
    end
    full_d = (occ_d == OCC_MAX);

    if (issue_c) state_d = (retire_c && (occ_d == '0)) ? RS_IDLE : RS_READ;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RS_IDLE;
      ptr_q   <= '0;
      bank_q  <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ren_q   <= '0;
      addr_q  <= '0;
      rbank_q <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      rbank_q <= rbank_d;
      last_q  <= last_d;
      // Enables reach the mux select after READ_LATENCY; valid one stage later.
      pipe_q[0] <= '{ren: ren_q, last: last_q};
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
      vld_q <= |pipe_q[READ_LATENCY-1].ren;
    end
  end

  dr_prb_framer #(
    .RE_PER_PRB (RE_PER_PRB),
    .NUM_PRB    (NUM_PRB),
    .PRB_W      (DR_PRB_W)
  ) u_framer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_vld      (|pipe_q[READ_LATENCY-1].ren),
    .i_blk_last (pipe_q[READ_LATENCY-1].last),
    .o_sop      (bus.o_tx_sop),
    .o_eop      (bus.o_tx_eop),
    .o_prb_idx  (bus.o_prb_idx)
  );

  assign bus.o_rd_ren    = ren_q;
  assign bus.o_rd_addr   = addr_q;
  assign bus.o_rd_bank   = rbank_q;
  assign bus.o_dout_sel  = pipe_q[READ_LATENCY-1].ren;
  assign bus.o_dout_vld  = vld_q;
  assign bus.o_occupancy = occ_q;
  assign bus.o_full      = full_q;
  assign bus.o_overflow  = ovf_q;

endmodule

// File: tb/tb_dr_buffer_rd_sched.sv
// Directed bench for dr_buffer_rd_sched with 24-word blocks and 2 PRBs per block.
module tb_dr_buffer_rd_sched;
  import dr_pkg::*;

  localparam int unsigned AW = 11;
  localparam int BD = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dr_buffer_rd_sched_if #(.RADDR_WIDTH(AW)) bus ();

  dr_buffer_rd_sched #(
    .RADDR_WIDTH  (AW),
    .BLK_DEPTH    (BD),
    .NUM_BLOCKS   (4),
    .READ_LATENCY (3),
    .RE_PER_PRB   (12),
    .NUM_PRB      (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_wr_wlast = 1'b0;
    bus.i_rready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int n);
    bus.i_wr_wlast = 1'b1;
    repeat (n) tick();
    bus.i_wr_wlast = 1'b0;
    chk("load_occ", bus.o_occupancy, n);
    chk("load_ren", bus.o_rd_ren, 0);
  endtask

  // Continuous rready over n preloaded blocks, starting from bank 0 after reset.
  task automatic run_burst(input string t, input int n);
    bus.i_rready = 1'b1;
    for (int j = 0; j < BD*n + 6; j++) begin
      int  w;
      int  occ_e;
      bit  vld_e;
      tick();
      w     = j - 4;
      vld_e = (j >= 4) && (w < BD*n);
      occ_e = n - (j + 1) / BD;
      if (occ_e < 0) occ_e = 0;
      chk({t, "_ren"},  bus.o_rd_ren,  (j < BD*n) ? (1 << (j / BD)) : 0);
      chk({t, "_addr"}, bus.o_rd_addr, (j < BD*n) ? (j % BD) : BD - 1);
      chk({t, "_bank"}, bus.o_rd_bank, (j < BD*n) ? (j / BD) : n - 1);
      chk({t, "_sel"},  bus.o_dout_sel, (j >= 3 && (j - 3) < BD*n) ? (1 << ((j - 3) / BD)) : 0);
      chk({t, "_vld"},  bus.o_dout_vld, vld_e);
      chk({t, "_sop"},  bus.o_tx_sop,  vld_e && (w % BD == 0));
      chk({t, "_eop"},  bus.o_tx_eop,  vld_e && (w % 12 == 11));
      if (vld_e) chk({t, "_prb"}, bus.o_prb_idx, (w % BD) / 12);
      chk({t, "_occ"},  bus.o_occupancy, occ_e);
      chk({t, "_full"}, bus.o_full, occ_e == 4);
    end
    bus.i_rready = 1'b0;
    chk({t, "_idle"}, dut.state_q, RS_IDLE);
  endtask

  // rready toggles mid-block; expected stream tracked by a tiny issue model.
  task automatic test_bubbles();
    bit         hist [64];
    int         issued = 0;
    int         wc = 0;
    int         last_addr = 0;
    do_reset();
    load(1);
    for (int s = 0; s < 36; s++) begin
      bit r;
      bit vld_e;
      r = (s >= 5 && s < 13) ? (s % 2 == 0) : 1'b1;
      bus.i_rready = r;
      tick();
      if (r && issued < BD) begin
        hist[s] = 1'b1;
        last_addr = issued;
        issued++;
      end else begin
        hist[s] = 1'b0;
      end
      chk("t3_ren",  bus.o_rd_ren, hist[s] ? 1 : 0);
      chk("t3_addr", bus.o_rd_addr, last_addr);
      chk("t3_occ",  bus.o_occupancy, (issued == BD) ? 0 : 1);
      vld_e = (s >= 4) && hist[s-4];
      chk("t3_vld",  bus.o_dout_vld, vld_e);
      if (vld_e) begin
        chk("t3_sop", bus.o_tx_sop, wc == 0);
        chk("t3_eop", bus.o_tx_eop, wc % 12 == 11);
        chk("t3_prb", bus.o_prb_idx, wc / 12);
        wc++;
      end else begin
        chk("t3_sop_idle", bus.o_tx_sop, 0);
        chk("t3_eop_idle", bus.o_tx_eop, 0);
      end
    end
    bus.i_rready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.i_wr_wlast = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t4_occ",  bus.o_occupancy, (k < 4) ? k : 4);
      chk("t4_full", bus.o_full, k >= 4);
      chk("t4_ovf",  bus.o_overflow, k >= 5);
    end
    bus.i_wr_wlast = 1'b0;
    tick();
    chk("t4_ovf_hold",  bus.o_overflow, 1);
    chk("t4_occ_hold",  bus.o_occupancy, 4);
    chk("t4_ren_held",  bus.o_rd_ren, 0);
    bus.i_rready = 1'b1;
    tick();
    tick();
    chk("t4_rd_ren",    bus.o_rd_ren, 1);
    chk("t4_rd_addr",   bus.o_rd_addr, 1);
    chk("t4_ovf_stick", bus.o_overflow, 1);
    chk("t4_occ_rd",    bus.o_occupancy, 4);
    bus.i_rready = 1'b0;
  endtask

  // wlast lands on the same edge that retires address 23.
  task automatic test_concurrent();
    do_reset();
    load(1);
    bus.i_rready = 1'b1;
    for (int j = 0; j < 2*BD + 4; j++) begin
      bus.i_wr_wlast = (j == BD - 1);
      tick();
      chk("t5_ren",  bus.o_rd_ren, (j < BD) ? 1 : ((j < 2*BD) ? 2 : 0));
      chk("t5_addr", bus.o_rd_addr, (j < 2*BD) ? (j % BD) : BD - 1);
      chk("t5_occ",  bus.o_occupancy, (j < 2*BD - 1) ? 1 : 0);
      chk("t5_vld",  bus.o_dout_vld, (j >= 4) && (j < 2*BD + 4));
      chk("t5_ovf",  bus.o_overflow, 0);
    end
    bus.i_wr_wlast = 1'b0;
    bus.i_rready   = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(1);
    bus.i_rready = 1'b1;
    for (int j = 0; j <= 10; j++) tick();
    chk("t6_pre_addr", bus.o_rd_addr, 10);
    chk("t6_pre_ren",  bus.o_rd_ren, 1);
    rst = 1'b1;
    tick();
    chk("t6_ren", bus.o_rd_ren, 0);
    chk("t6_occ", bus.o_occupancy, 0);
    chk("t6_ovf", bus.o_overflow, 0);
    chk("t6_vld", bus.o_dout_vld, 0);
    chk("t6_sel", bus.o_dout_sel, 0);
    rst = 1'b0;
    bus.i_rready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t6_vld_after", bus.o_dout_vld, 0);
      chk("t6_sop_after", bus.o_tx_sop, 0);
      chk("t6_eop_after", bus.o_tx_eop, 0);
    end
    load(1);
    run_burst("t6_restart", 1);
  endtask

  initial begin
    bus.i_wr_wlast = 1'b0;
    bus.i_rready   = 1'b0;

    do_reset();
    chk("rst_ren",  bus.o_rd_ren, 0);
    chk("rst_addr", bus.o_rd_addr, 0);
    chk("rst_bank", bus.o_rd_bank, 0);
    chk("rst_sel",  bus.o_dout_sel, 0);
    chk("rst_vld",  bus.o_dout_vld, 0);
    chk("rst_sop",  bus.o_tx_sop, 0);
    chk("rst_eop",  bus.o_tx_eop, 0);
    chk("rst_prb",  bus.o_prb_idx, 0);
    chk("rst_occ",  bus.o_occupancy, 0);
    chk("rst_full", bus.o_full, 0);
    chk("rst_ovf",  bus.o_overflow, 0);

    load(1);
    run_burst("t1", 1);

    do_reset();
    load(2);
    run_burst("t2", 2);

    test_bubbles();
    test_overflow();
    test_concurrent();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
